systolic_seq_ctrl: RTL and testbench

Job sequencer for the 2x2 systolic matrix-multiply array. It accepts one pair of 2x2 operand matrices per job through a valid/ready handshake and clears the array. It then feeds the operands into the array's row and column lanes with the diagonal skew the array needs. After waiting a programmable drain period, it captures the four 64-bit results and their carry bits and holds them until the consumer accepts them. It sits between the job source (host or DMA front end) and the array instance in the matrix-multiplier top level.

---
 rtl/systolic_seq_ctrl_pkg.sv | 33 +++
 rtl/systolic_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared matrix-multiplier definitions: sequencer states, datapath widths and
// helpers for addressing elements inside the flat operand vectors.
package systolic_seq_ctrl_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned DIM    = 2;
  localparam int unsigned MAT_W  = DIM * DIM * LANE_W;
  localparam int unsigned CMAT_W = DIM * DIM * RES_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED0   = 3'd2,
    ST_FEED1   = 3'd3,
    ST_FEED2   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_CAPTURE = 3'd6,
    ST_DONE    = 3'd7
  } seq_state_t;

  // Flat vectors are packed row-major with element (0,0) in the low bits.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
    return r * DIM + c;
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [MAT_W-1:0] m,
                                                input int unsigned r,
                                                input int unsigned c);
    return m[elem_idx(r, c) * LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 2x2 systolic array: latches operands, clears the array,
// feeds skewed lanes, waits for drain, then holds the captured results.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CLR_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAT_W-1:0]  a_flat,
  input  logic [MAT_W-1:0]  b_flat,
  output logic              arr_clr,
  output logic              arr_load,
  output logic [LANE_W-1:0] arr_row0,
  output logic [LANE_W-1:0] arr_row1,
  output logic [LANE_W-1:0] arr_col0,
  output logic [LANE_W-1:0] arr_col1,
  input  logic [RES_W-1:0]  arr_res00,
  input  logic [RES_W-1:0]  arr_res01,
  input  logic [RES_W-1:0]  arr_res10,
  input  logic [RES_W-1:0]  arr_res11,
  input  logic [3:0]        arr_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMAT_W-1:0] c_flat,
  output logic [3:0]        c_carry,
  output logic              busy
);

  localparam logic [3:0] CLR_LOAD   = 4'(CLR_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  seq_state_t       state;
  logic [3:0]       cnt;
  logic [MAT_W-1:0] a_q;
  logic [MAT_W-1:0] b_q;

  assign busy = (state != ST_IDLE);

  // Every array-facing signal is set on the transition into the state that
  // needs it, so the array only ever sees register outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      arr_clr   <= 1'b0;
      arr_load  <= 1'b0;
      arr_row0  <= '0;
      arr_row1  <= '0;
      arr_col0  <= '0;
      arr_col1  <= '0;
      out_valid <= 1'b0;
      c_flat    <= '0;
      c_carry   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a_flat;
            b_q      <= b_flat;
            in_ready <= 1'b0;
            arr_clr  <= 1'b1;
            cnt      <= CLR_LOAD;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (cnt == 4'd0) begin
            arr_clr  <= 1'b0;
            arr_load <= 1'b1;
            arr_row0 <= lane_of(a_q, 0, 0);
            arr_col0 <= lane_of(b_q, 0, 0);
            state    <= ST_FEED0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_FEED0: begin
          arr_row0 <= lane_of(a_q, 0, 1);
          arr_row1 <= lane_of(a_q, 1, 0);
          arr_col0 <= lane_of(b_q, 1, 0);
          arr_col1 <= lane_of(b_q, 0, 1);
          state    <= ST_FEED1;
        end
        ST_FEED1: begin
          arr_row0 <= '0;
          arr_row1 <= lane_of(a_q, 1, 1);
          arr_col0 <= '0;
          arr_col1 <= lane_of(b_q, 1, 1);
          state    <= ST_FEED2;
        end
        ST_FEED2: begin
          arr_row0 <= '0;
          arr_row1 <= '0;
          arr_col0 <= '0;
          arr_col1 <= '0;
          cnt      <= DRAIN_LOAD;
          state    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt == 4'd0) begin
            arr_load <= 1'b0;
            state    <= ST_CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          c_flat    <= {arr_res11, arr_res10, arr_res01, arr_res00};
          c_carry   <= arr_carry;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl driving a behavioural 2x2 unsigned
// systolic array so that end-to-end products can be checked.
module tb_systolic_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a_flat;
  logic [127:0] b_flat;
  logic         arr_clr;
  logic         arr_load;
  logic [31:0]  arr_row0, arr_row1, arr_col0, arr_col1;
  logic [63:0]  arr_res00, arr_res01, arr_res10, arr_res11;
  logic [3:0]   arr_carry;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] c_flat;
  logic [3:0]   c_carry;
  logic         busy;

  int tests = 0;
  int fails = 0;

  systolic_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_flat(a_flat), .b_flat(b_flat), .arr_clr(arr_clr), .arr_load(arr_load),
    .arr_row0(arr_row0), .arr_row1(arr_row1), .arr_col0(arr_col0), .arr_col1(arr_col1),
    .arr_res00(arr_res00), .arr_res01(arr_res01), .arr_res10(arr_res10), .arr_res11(arr_res11),
    .arr_carry(arr_carry), .out_valid(out_valid), .out_ready(out_ready),
    .c_flat(c_flat), .c_carry(c_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary 2x2 array: A flows right, B flows down.
  logic [31:0] pa00, pb00, pb01, pa10;
  logic [63:0] acc [4];
  logic [3:0]  cy;

  function automatic logic [64:0] mac(input logic [63:0] acc_in, input logic [31:0] a,
                                      input logic [31:0] b);
    return {1'b0, acc_in} + {1'b0, 64'(a) * 64'(b)};
  endfunction

  always @(posedge clk) begin
    if (rst || arr_clr) begin
      pa00 <= '0; pb00 <= '0; pb01 <= '0; pa10 <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      cy <= '0;
    end else if (arr_load) begin
      logic [64:0] s0, s1, s2, s3;
      s0 = mac(acc[0], arr_row0, arr_col0);
      s1 = mac(acc[1], pa00, arr_col1);
      s2 = mac(acc[2], arr_row1, pb00);
      s3 = mac(acc[3], pa10, pb01);
      acc[0] <= s0[63:0]; acc[1] <= s1[63:0]; acc[2] <= s2[63:0]; acc[3] <= s3[63:0];
      cy <= cy | {s3[64], s2[64], s1[64], s0[64]};
      pa00 <= arr_row0; pb00 <= arr_col0; pb01 <= arr_col1; pa10 <= arr_row1;
    end
  end

  assign arr_res00 = acc[0];
  assign arr_res01 = acc[1];
  assign arr_res10 = acc[2];
  assign arr_res11 = acc[3];
  assign arr_carry = cy;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, counting cycles from the accept edge; bounded.
  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [255:0] cmat(input logic [63:0] c11, input logic [63:0] c10,
                                        input logic [63:0] c01, input logic [63:0] c00);
    return {c11, c10, c01, c00};
  endfunction

  initial begin
    int lat;
    int seen;
    logic [255:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_flat = '0; b_flat = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_ctrl", {out_valid, busy, arr_clr, arr_load}, 0);
    check("rst_lanes", {arr_row0, arr_row1, arr_col0, arr_col1}, 0);
    check("rst_c", {c_flat, c_carry}, 0);
    rst = 1'b0;
    tick();

    // Job 1: basic multiply, lane schedule, then backpressure
    a_flat = {32'd4, 32'd3, 32'd2, 32'd1};
    b_flat = {32'd8, 32'd7, 32'd6, 32'd5};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("clear_ctrl", {arr_clr, arr_load, busy, in_ready}, 4'b1010);
    check("clear_lanes", {arr_row0, arr_row1, arr_col0, arr_col1}, 0);
    tick();
    check("feed0", {arr_clr, arr_load, arr_row0, arr_row1, arr_col0, arr_col1},
          {2'b01, 32'd1, 32'd0, 32'd5, 32'd0});
    tick();
    check("feed1", {arr_clr, arr_load, arr_row0, arr_row1, arr_col0, arr_col1},
          {2'b01, 32'd2, 32'd3, 32'd7, 32'd6});
    tick();
    check("feed2", {arr_clr, arr_load, arr_row0, arr_row1, arr_col0, arr_col1},
          {2'b01, 32'd0, 32'd4, 32'd0, 32'd8});
    tick();
    check("drain", {arr_clr, arr_load, arr_row0, arr_row1, arr_col0, arr_col1},
          {2'b01, 128'd0});
    wait_valid(4, lat);
    check("lat_job1", lat, 8);
    check("c_job1", c_flat, cmat(64'd50, 64'd43, 64'd22, 64'd19));
    check("carry_job1", c_carry, 0);
    held = c_flat;
    in_valid = 1'b1;
    a_flat = {4{32'hDEAD_BEEF}};
    b_flat = {4{32'h1234_5678}};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", {out_valid, in_ready, busy, c_flat}, {3'b101, held});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {out_valid, in_ready, busy}, 3'b010);

    // Job 2: back-to-back, out_ready held high before out_valid
    a_flat = {32'd1, 32'd0, 32'd0, 32'd1};
    b_flat = {32'd12, 32'd11, 32'd10, 32'd9};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(0, lat);
    check("lat_job2", lat, 8);
    check("c_job2", c_flat, cmat(64'd12, 64'd11, 64'd10, 64'd9));
    check("carry_job2", c_carry, 0);

    // Job 3: overflow, offered so it is accepted on the first in_ready edge
    a_flat = {4{32'hFFFF_FFFF}};
    b_flat = {4{32'hFFFF_FFFF}};
    in_valid = 1'b1;
    tick();
    check("hs_job2", {out_valid, in_ready}, 2'b01);
    tick();
    in_valid = 1'b0;
    check("accept_job3", {in_ready, arr_clr}, 2'b01);
    wait_valid(0, lat);
    check("lat_job3", lat, 8);
    check("c_ovf", c_flat, {4{64'hFFFF_FFFC_0000_0002}});
    check("carry_ovf", c_carry, 4'b1111);
    tick();

    // Job 4: reset during FEED1
    out_ready = 1'b0;
    a_flat = {32'd4, 32'd3, 32'd2, 32'd1};
    b_flat = {32'd8, 32'd7, 32'd6, 32'd5};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_feed1", {arr_row0, arr_row1}, {32'd2, 32'd3});
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {in_ready, out_valid, busy, arr_clr, arr_load}, 5'b10000);
    check("mid_rst_data", {arr_row0, arr_row1, arr_col0, arr_col1, c_flat, c_carry}, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    check("idle_after_rst", {in_ready, busy}, 2'b10);

    // Job 5: normal operation after reset
    out_ready = 1'b1;
    a_flat = {32'd2, 32'd0, 32'd0, 32'd2};
    b_flat = {32'd8, 32'd7, 32'd6, 32'd5};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(0, lat);
    check("lat_job5", lat, 8);
    check("c_job5", c_flat, cmat(64'd16, 64'd14, 64'd12, 64'd10));
    check("carry_job5", c_carry, 0);
    tick();
    check("end_idle", {out_valid, in_ready, busy}, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
